contador_estacionamiento: RTL and testbench
===========================================

Name: contador_estacionamiento

Overview:
- Downstream stage of the parking entry/exit detector.
- Consumes its one-cycle `entrada`/`salida` pulses and keeps the lot's occupancy count, free-space count and full/empty status.
- Flags sticky overflow/underflow errors and mirrors the count as two BCD digits for the lot's 7-segment display driver.

Parameters:
- CAPACIDAD, 20, number of parking spaces; legal range 1..99.
- W, 7, width of `ocupados`/`libres`; must hold 99.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- entrada  input  1  vehicle-entered pulse from the detector.
- salida  input  1  vehicle-left pulse from the detector.
- clear_err  input  1  clears the sticky error flags.
- ocupados  output  W  occupied spaces, 0..CAPACIDAD.
- libres  output  W  free spaces, always CAPACIDAD - ocupados.
- lleno  output  1  high when ocupados == CAPACIDAD.
- vacio  output  1  high when ocupados == 0.
- err_overflow  output  1  sticky; an entry arrived while full.
- err_underflow  output  1  sticky; an exit arrived while empty.
- bcd_dec  output  4  tens digit of ocupados.
- bcd_uni  output  4  units digit of ocupados.

Behaviour:
- Reset: one clock with reset high drives ocupados=0, libres=CAPACIDAD, vacio=1, lleno=0, err_*=0, bcd_dec=0, bcd_uni=0.
  - Reset overrides every other input.
  - Reset mid-sequence discards any pulse present in the same cycle.
- All outputs are registered. Latency: a pulse sampled at edge N is reflected in the outputs after edge N.
- Input sampling:
  - Inputs are sampled every cycle; each high cycle counts as one event.
  - A level held high for k cycles counts k events. The detector guarantees single-cycle pulses.
- Occupancy FSM has three states: VACIO, PARCIAL, LLENO.
  - VACIO: entrada-only -> count 1; go to LLENO if CAPACIDAD==1, else PARCIAL. salida-only -> set err_underflow, stay.
  - PARCIAL: entrada-only -> +1; go to LLENO when the count reaches CAPACIDAD. salida-only -> -1; go to VACIO when the count reaches 0.
  - LLENO: entrada-only -> set err_overflow, count unchanged, stay. salida-only -> -1; go to PARCIAL, or VACIO if CAPACIDAD==1.
  - The state encoding drives lleno/vacio directly. lleno and vacio are never both high.
- Simultaneous entrada & salida: net zero. No count change and no error, in every state including VACIO and LLENO.
- Arithmetic:
  - ocupados never leaves 0..CAPACIDAD; there is no wrap-around.
  - libres is updated in the same cycle as ocupados.
- BCD counter:
  - Maintained in lockstep with the binary count, not derived combinationally.
  - Increment: units 9->0 with carry into tens.
  - Decrement: units 0->9 with borrow from tens.
  - Invariant every cycle: bcd_dec*10 + bcd_uni == ocupados.
- Error flags:
  - Set on the offending event and held until clear_err.
  - If clear_err and a new offending event occur in the same cycle, the flag ends set.
  - clear_err never affects the count.
- Unused/illegal FSM encodings recover to VACIO on the next edge, with count and BCD forced to 0.

Decomposition:
- Shared package (also used by the detector):
  - Sensor encodings IDLE/A_ON/AB_ON/B_ON.
  - Occupancy state encodings VACIO/PARCIAL/LLENO.
  - Maximum legal capacity, 99.
- Sub-module `bcd_digito_updown`: one decade up/down counter.
  - Inputs: inc, dec.
  - Outputs: digit, carry, borrow.
  - Sync reset to 0.
  - Instantiated twice, chained units -> tens.

Test Plan:
- Reset then idle 5 cycles -> ocupados=0, libres=20, vacio=1, lleno=0, bcd=0/0, errors 0.
- 12 entrada pulses, one every 3 cycles -> ocupados=12, libres=8, bcd_dec=1, bcd_uni=2; the units digit wraps 9->0 with carry on the 10th pulse.
- Fill to 20, then one more entrada -> ocupados stays 20, lleno=1, err_overflow=1. clear_err next cycle -> err_overflow=0, count still 20.
- From empty, salida pulse -> err_underflow=1, ocupados=0, vacio=1. Then an entrada with clear_err the same cycle -> ocupados=1, err_underflow=0.
- At ocupados=20, entrada&salida together -> no change, no error. At ocupados=10, salida -> 9, bcd=0/9 via borrow.
- Reset asserted the same cycle as an entrada at ocupados=7 -> next cycle ocupados=0, all outputs at reset values. Repeat with CAPACIDAD=1 -> VACIO<->LLENO directly.

Source files
------------

// File: rtl/contador_estacionamiento_pkg.sv
// Shared encodings for the parking entry/exit detector and the occupancy counter.
// Occupancy states are encoded as {lleno, vacio} so the state bits drive those outputs.
package contador_estacionamiento_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    A_ON  = 2'b01,
    AB_ON = 2'b11,
    B_ON  = 2'b10
  } sensor_t;

  typedef enum logic [1:0] {
    PARCIAL = 2'b00,
    VACIO   = 2'b01,
    LLENO   = 2'b10
  } ocupacion_t;

  localparam int CAPACIDAD_MAX = 99;

endpackage

// File: rtl/bcd_digito_updown.sv
// One decade of an up/down BCD counter; carry/borrow flag the wrap so decades can be chained.
module bcd_digito_updown (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       carry,
  output logic       borrow
);

  assign carry  = inc & ~dec & (digit == 4'd9);
  assign borrow = dec & ~inc & (digit == 4'd0);

  // Digit register: wraps 9->0 upward and 0->9 downward.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (inc & ~dec) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end else if (dec & ~inc) begin
      digit <= borrow ? 4'd9 : digit - 4'd1;
    end else begin
      digit <= digit;
    end
  end

endmodule

// File: rtl/contador_estacionamiento.sv
// Parking lot occupancy counter: saturating count, free spaces, full/empty state,
// sticky overflow/underflow flags and a two-digit BCD mirror of the count.
module contador_estacionamiento
  import contador_estacionamiento_pkg::*;
#(
  parameter int CAPACIDAD = 20,
  parameter int W         = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         entrada,
  input  logic         salida,
  input  logic         clear_err,
  output logic [W-1:0] ocupados,
  output logic [W-1:0] libres,
  output logic         lleno,
  output logic         vacio,
  output logic         err_overflow,
  output logic         err_underflow,
  output logic [3:0]   bcd_dec,
  output logic [3:0]   bcd_uni
);

  localparam logic [W-1:0] CAP = W'(CAPACIDAD);

  ocupacion_t   state, state_next;
  logic [W-1:0] count_next;
  logic         sube, baja, set_ovf, set_unf, ilegal;
  logic         ev_in, ev_out;
  logic         uni_carry, uni_borrow, dec_carry, dec_borrow;

  assign ev_in  = entrada & ~salida;
  assign ev_out = salida & ~entrada;

  // Next-state and count arithmetic; simultaneous pulses are a net no-op.
  always_comb begin
    state_next = state;
    count_next = ocupados;
    sube       = 1'b0;
    baja       = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    ilegal     = 1'b0;
    case (state)
      VACIO: begin
        if (ev_in) begin
          count_next = W'(1);
          sube       = 1'b1;
          state_next = (CAPACIDAD == 1) ? LLENO : PARCIAL;
        end else if (ev_out) begin
          set_unf = 1'b1;
        end else begin
          state_next = VACIO;
        end
      end
      PARCIAL: begin
        if (ev_in) begin
          count_next = ocupados + W'(1);
          sube       = 1'b1;
          state_next = (ocupados + W'(1) == CAP) ? LLENO : PARCIAL;
        end else if (ev_out) begin
          count_next = ocupados - W'(1);
          baja       = 1'b1;
          state_next = (ocupados == W'(1)) ? VACIO : PARCIAL;
        end else begin
          state_next = PARCIAL;
        end
      end
      LLENO: begin
        if (ev_in) begin
          set_ovf = 1'b1;
        end else if (ev_out) begin
          count_next = ocupados - W'(1);
          baja       = 1'b1;
          state_next = (CAPACIDAD == 1) ? VACIO : PARCIAL;
        end else begin
          state_next = LLENO;
        end
      end
      default: begin
        ilegal     = 1'b1;
        state_next = VACIO;
        count_next = '0;
      end
    endcase
  end

  // State, count and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= VACIO;
      ocupados      <= '0;
      libres        <= CAP;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_next;
      ocupados      <= count_next;
      libres        <= CAP - count_next;
      err_overflow  <= set_ovf | (err_overflow & ~clear_err);
      err_underflow <= set_unf | (err_underflow & ~clear_err);
    end
  end

  assign lleno = state[1];
  assign vacio = state[0];

  bcd_digito_updown u_unidades (
    .clk    (clk),
    .reset  (reset | ilegal),
    .inc    (sube),
    .dec    (baja),
    .digit  (bcd_uni),
    .carry  (uni_carry),
    .borrow (uni_borrow)
  );

  bcd_digito_updown u_decenas (
    .clk    (clk),
    .reset  (reset | ilegal),
    .inc    (uni_carry),
    .dec    (uni_borrow),
    .digit  (bcd_dec),
    .carry  (dec_carry),
    .borrow (dec_borrow)
  );

endmodule

// File: tb/tb_contador_estacionamiento.sv
// Self-checking bench: directed scenarios plus random pulses against a plain arithmetic
// occupancy model, on a 20-space lot (index 0) and a 1-space lot (index 1).
module tb_contador_estacionamiento;

  logic            clk = 1'b0;
  logic [1:0]      rst, ent, sal, clr;
  logic [1:0][6:0] ocu, lib;
  logic [1:0]      ful, emp, ovf, unf;
  logic [1:0][3:0] bd, bu;
  logic [1:0]      unused_c;

  int checks   = 0;
  int failures = 0;
  int occ_m[2];
  bit ovf_m[2];
  bit unf_m[2];
  int cap_m[2] = '{20, 1};

  always #5 clk = ~clk;

  contador_estacionamiento #(.CAPACIDAD(20), .W(7)) dut0 (
    .clk(clk), .reset(rst[0]), .entrada(ent[0]), .salida(sal[0]), .clear_err(clr[0]),
    .ocupados(ocu[0]), .libres(lib[0]), .lleno(ful[0]), .vacio(emp[0]),
    .err_overflow(ovf[0]), .err_underflow(unf[0]), .bcd_dec(bd[0]), .bcd_uni(bu[0])
  );

  contador_estacionamiento #(.CAPACIDAD(1), .W(7)) dut1 (
    .clk(clk), .reset(rst[1]), .entrada(ent[1]), .salida(sal[1]), .clear_err(clr[1]),
    .ocupados(ocu[1]), .libres(lib[1]), .lleno(ful[1]), .vacio(emp[1]),
    .err_overflow(ovf[1]), .err_underflow(unf[1]), .bcd_dec(bd[1]), .bcd_uni(bu[1])
  );

  assign unused_c = '0;

  // One clock on lot d with the given inputs; the model follows the occupancy rules.
  task automatic step(input int d, input bit e, input bit s, input bit c, input bit r);
    bit so, su;
    ent[d] = e; sal[d] = s; clr[d] = c; rst[d] = r;
    @(posedge clk);
    so = 1'b0; su = 1'b0;
    if (r) begin
      occ_m[d] = 0; ovf_m[d] = 1'b0; unf_m[d] = 1'b0;
    end else begin
      if (e && !s) begin
        if (occ_m[d] == cap_m[d]) so = 1'b1; else occ_m[d] = occ_m[d] + 1;
      end
      if (s && !e) begin
        if (occ_m[d] == 0) su = 1'b1; else occ_m[d] = occ_m[d] - 1;
      end
      ovf_m[d] = so | (ovf_m[d] & !c);
      unf_m[d] = su | (unf_m[d] & !c);
    end
    #1;
    ent[d] = 1'b0; sal[d] = 1'b0; clr[d] = 1'b0; rst[d] = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks += 6;
    if (ocu[0] !== 7'd0) begin failures++; $display("FAIL reset_ocupados got %0d expected 0", ocu[0]); end
    if (lib[0] !== 7'd20) begin failures++; $display("FAIL reset_libres got %0d expected 20", lib[0]); end
    if (emp[0] !== 1'b1 || ful[0] !== 1'b0) begin
      failures++; $display("FAIL reset_flags got vacio=%0b lleno=%0b expected 1/0", emp[0], ful[0]);
    end
    if (ovf[0] !== 1'b0 || unf[0] !== 1'b0) begin
      failures++; $display("FAIL reset_err got %0b%0b expected 00", ovf[0], unf[0]);
    end
    if (bd[0] !== 4'd0) begin failures++; $display("FAIL reset_bcd_dec got %0d expected 0", bd[0]); end
    if (bu[0] !== 4'd0) begin failures++; $display("FAIL reset_bcd_uni got %0d expected 0", bu[0]); end
  endtask

  task automatic test_fill_12();
    for (int i = 1; i <= 12; i++) begin
      step(0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 9 || i == 10) begin
        checks++;
        if ({bd[0], bu[0]} !== ((i == 9) ? 8'h09 : 8'h10)) begin
          failures++; $display("FAIL bcd_carry_%0d got %0d%0d expected %0d", i, bd[0], bu[0], i);
        end
      end
      step(0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks += 3;
    if (ocu[0] !== 7'd12) begin failures++; $display("FAIL fill12_ocupados got %0d expected 12", ocu[0]); end
    if (lib[0] !== 7'd8) begin failures++; $display("FAIL fill12_libres got %0d expected 8", lib[0]); end
    if (bd[0] !== 4'd1 || bu[0] !== 4'd2) begin
      failures++; $display("FAIL fill12_bcd got %0d/%0d expected 1/2", bd[0], bu[0]);
    end
  endtask

  task automatic test_overflow();
    while (occ_m[0] < 20) step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks += 3;
    if (ocu[0] !== 7'd20) begin failures++; $display("FAIL ovf_ocupados got %0d expected 20", ocu[0]); end
    if (ful[0] !== 1'b1 || emp[0] !== 1'b0) begin
      failures++; $display("FAIL ovf_lleno got lleno=%0b vacio=%0b expected 1/0", ful[0], emp[0]);
    end
    if (ovf[0] !== 1'b1) begin failures++; $display("FAIL ovf_flag got %0b expected 1", ovf[0]); end
    step(0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks += 2;
    if (ovf[0] !== 1'b0) begin failures++; $display("FAIL ovf_clear got %0b expected 0", ovf[0]); end
    if (ocu[0] !== 7'd20 || lib[0] !== 7'd0) begin
      failures++; $display("FAIL ovf_clear_count got %0d/%0d expected 20/0", ocu[0], lib[0]);
    end
  endtask

  task automatic test_underflow();
    step(0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (unf[0] !== 1'b1) begin failures++; $display("FAIL unf_flag got %0b expected 1", unf[0]); end
    if (ocu[0] !== 7'd0 || emp[0] !== 1'b1) begin
      failures++; $display("FAIL unf_count got %0d vacio=%0b expected 0/1", ocu[0], emp[0]);
    end
    step(0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks += 2;
    if (ocu[0] !== 7'd1) begin failures++; $display("FAIL unf_entry got %0d expected 1", ocu[0]); end
    if (unf[0] !== 1'b0) begin failures++; $display("FAIL unf_clear got %0b expected 0", unf[0]); end
    step(0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (unf[0] !== 1'b1) begin failures++; $display("FAIL unf_clear_and_set got %0b expected 1", unf[0]); end
  endtask

  task automatic test_simultaneous();
    step(0, 1'b0, 1'b0, 1'b1, 1'b0);
    while (occ_m[0] < 20) step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (ocu[0] !== 7'd20 || ful[0] !== 1'b1) begin
      failures++; $display("FAIL simul_full got %0d lleno=%0b expected 20/1", ocu[0], ful[0]);
    end
    if (ovf[0] !== 1'b0 || unf[0] !== 1'b0) begin
      failures++; $display("FAIL simul_err got %0b%0b expected 00", ovf[0], unf[0]);
    end
    while (occ_m[0] > 10) step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (ocu[0] !== 7'd9 || lib[0] !== 7'd11) begin
      failures++; $display("FAIL borrow_count got %0d/%0d expected 9/11", ocu[0], lib[0]);
    end
    if (bd[0] !== 4'd0 || bu[0] !== 4'd9) begin
      failures++; $display("FAIL borrow_bcd got %0d/%0d expected 0/9", bd[0], bu[0]);
    end
  endtask

  task automatic test_reset_mid();
    while (occ_m[0] > 7) step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks += 3;
    if (ocu[0] !== 7'd0 || lib[0] !== 7'd20) begin
      failures++; $display("FAIL rstmid_count got %0d/%0d expected 0/20", ocu[0], lib[0]);
    end
    if (emp[0] !== 1'b1 || ful[0] !== 1'b0 || {bd[0], bu[0]} !== 8'h00) begin
      failures++; $display("FAIL rstmid_flags got vacio=%0b lleno=%0b bcd=%0d%0d", emp[0], ful[0], bd[0], bu[0]);
    end
    if (ovf[0] !== 1'b0 || unf[0] !== 1'b0) begin
      failures++; $display("FAIL rstmid_err got %0b%0b expected 00", ovf[0], unf[0]);
    end
  endtask

  task automatic test_cap1();
    step(1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ocu[1] !== 7'd0 || lib[1] !== 7'd1 || emp[1] !== 1'b1 || ful[1] !== 1'b0) begin
      failures++; $display("FAIL cap1_reset got %0d/%0d v=%0b l=%0b expected 0/1 1/0", ocu[1], lib[1], emp[1], ful[1]);
    end
    step(1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ocu[1] !== 7'd1 || ful[1] !== 1'b1 || emp[1] !== 1'b0 || bu[1] !== 4'd1) begin
      failures++; $display("FAIL cap1_fill got %0d l=%0b v=%0b expected 1 1/0", ocu[1], ful[1], emp[1]);
    end
    step(1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ovf[1] !== 1'b1 || ocu[1] !== 7'd1) begin
      failures++; $display("FAIL cap1_ovf got ovf=%0b count=%0d expected 1/1", ovf[1], ocu[1]);
    end
    step(1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ocu[1] !== 7'd0 || emp[1] !== 1'b1 || ful[1] !== 1'b0 || lib[1] !== 7'd1) begin
      failures++; $display("FAIL cap1_empty got %0d v=%0b l=%0b expected 0 1/0", ocu[1], emp[1], ful[1]);
    end
  endtask

  task automatic test_random();
    bit e, s, c;
    step(0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      e = ($urandom_range(0, 99) < 40);
      s = ($urandom_range(0, 99) < ((i % 300) < 150 ? 25 : 55));
      c = ($urandom_range(0, 99) < 5);
      step(0, e, s, c, ($urandom_range(0, 999) == 0));
      checks++;
      if (ocu[0] !== 7'(occ_m[0]) || lib[0] !== 7'(20 - occ_m[0]) ||
          ful[0] !== (occ_m[0] == 20) || emp[0] !== (occ_m[0] == 0) ||
          ovf[0] !== ovf_m[0] || unf[0] !== unf_m[0] ||
          bd[0] !== 4'(occ_m[0] / 10) || bu[0] !== 4'(occ_m[0] % 10)) begin
        failures++;
        $display("FAIL random_%0d got occ=%0d lib=%0d l=%0b v=%0b ovf=%0b unf=%0b bcd=%0d%0d expected occ=%0d ovf=%0b unf=%0b",
                 i, ocu[0], lib[0], ful[0], emp[0], ovf[0], unf[0], bd[0], bu[0], occ_m[0], ovf_m[0], unf_m[0]);
      end
    end
  endtask

  initial begin
    rst = 2'b00; ent = 2'b00; sal = 2'b00; clr = 2'b00;
    occ_m = '{0, 0}; ovf_m = '{1'b0, 1'b0}; unf_m = '{1'b0, 1'b0};
    #2;
    test_reset();
    test_fill_12();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    test_cap1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
